// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signal bundle for alu_cmd_sequencer.
// slave = sequencer side, master = control path / ALU / response consumer side.
interface alu_cmd_sequencer_if;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [4:0] Cmd_Opcode;
    logic [1:0] Cmd_Sel;
    logic       Cmd_CarryIn;
    logic [7:0] Cmd_A;
    logic [7:0] Cmd_B;
    logic       Cmd_Chain;

    logic [4:0] Alu_Opcode;
    logic [1:0] Alu_Sel;
    logic       Alu_CarryIn;
    logic [7:0] Alu_A;
    logic [7:0] Alu_B;
    logic [7:0] Alu_Out;
    logic       Alu_CarryOut;
    logic       Alu_Overflow;

    logic       Rsp_Valid;
    logic       Rsp_Ready;
    logic [7:0] Rsp_Data;
    logic       Rsp_Carry;
    logic       Rsp_Ovf;

    modport slave (
        input  Cmd_Valid, Cmd_Opcode, Cmd_Sel, Cmd_CarryIn, Cmd_A, Cmd_B, Cmd_Chain,
        input  Alu_Out, Alu_CarryOut, Alu_Overflow, Rsp_Ready,
        output Cmd_Ready, Alu_Opcode, Alu_Sel, Alu_CarryIn, Alu_A, Alu_B,
        output Rsp_Valid, Rsp_Data, Rsp_Carry, Rsp_Ovf
    );

    modport master (
        output Cmd_Valid, Cmd_Opcode, Cmd_Sel, Cmd_CarryIn, Cmd_A, Cmd_B, Cmd_Chain,
        output Alu_Out, Alu_CarryOut, Alu_Overflow, Rsp_Ready,
        input  Cmd_Ready, Alu_Opcode, Alu_Sel, Alu_CarryIn, Alu_A, Alu_B,
        input  Rsp_Valid, Rsp_Data, Rsp_Carry, Rsp_Ovf
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues one command at a time to a combinational ALU, holds operands SETTLE_CYCLES, returns result.
// Optional ALU_SEQ_CHAIN_EN: accumulator/stored-carry chaining selected per command by Cmd_Chain.
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  ACC_RESET     = 8'h00
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    alu_cmd_sequencer_if.slave    bus
);
    localparam int unsigned CNT_W  = 4;
    localparam logic [4:0]  OP_ADD = 5'b00001;
    localparam logic [4:0]  OP_MUL = 5'b00011;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         alu_op_q, alu_op_d;
    logic [1:0]         alu_sel_q, alu_sel_d;
    logic               alu_cin_q, alu_cin_d;
    logic [7:0]         alu_a_q, alu_a_d;
    logic [7:0]         alu_b_q, alu_b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic               carry_mask_c;

`ifdef ALU_SEQ_CHAIN_EN
    logic [7:0]         acc_q, acc_d;
    logic               cy_q, cy_d;
`else
    logic               chain_unused;
    logic [7:0]         acc_reset_unused;
    assign chain_unused     = bus.Cmd_Chain;
    assign acc_reset_unused = ACC_RESET;
`endif

    // ALU flags are only meaningful for their own opcode; mask stale values
    assign carry_mask_c = (alu_op_q == OP_ADD) & bus.Alu_CarryOut;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_op_d    = alu_op_q;
        alu_sel_d   = alu_sel_q;
        alu_cin_d   = alu_cin_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_ovf_d   = rsp_ovf_q;
`ifdef ALU_SEQ_CHAIN_EN
        acc_d       = acc_q;
        cy_d        = cy_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.Cmd_Valid) begin
                    alu_op_d  = bus.Cmd_Opcode;
                    alu_sel_d = bus.Cmd_Sel;
                    alu_b_d   = bus.Cmd_B;
`ifdef ALU_SEQ_CHAIN_EN
                    alu_a_d   = bus.Cmd_Chain ? acc_q : bus.Cmd_A;
                    alu_cin_d = bus.Cmd_Chain ? cy_q  : bus.Cmd_CarryIn;
`else
                    alu_a_d   = bus.Cmd_A;
                    alu_cin_d = bus.Cmd_CarryIn;
`endif
                    cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.Alu_Out;
                    rsp_carry_d = carry_mask_c;
                    rsp_ovf_d   = (alu_op_q == OP_MUL) & bus.Alu_Overflow;
`ifdef ALU_SEQ_CHAIN_EN
                    acc_d       = bus.Alu_Out;
                    cy_d        = carry_mask_c;
`endif
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.Rsp_Ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_op_q    <= '0;
            alu_sel_q   <= '0;
            alu_cin_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_ovf_q   <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            acc_q       <= ACC_RESET;
            cy_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_op_q    <= alu_op_d;
            alu_sel_q   <= alu_sel_d;
            alu_cin_q   <= alu_cin_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_ovf_q   <= rsp_ovf_d;
`ifdef ALU_SEQ_CHAIN_EN
            acc_q       <= acc_d;
            cy_q        <= cy_d;
`endif
        end
    end

    assign bus.Cmd_Ready   = (state_q == IDLE);
    assign bus.Alu_Opcode  = alu_op_q;
    assign bus.Alu_Sel     = alu_sel_q;
    assign bus.Alu_CarryIn = alu_cin_q;
    assign bus.Alu_A       = alu_a_q;
    assign bus.Alu_B       = alu_b_q;
    assign bus.Rsp_Valid   = rsp_valid_q;
    assign bus.Rsp_Data    = rsp_data_q;
    assign bus.Rsp_Carry   = rsp_carry_q;
    assign bus.Rsp_Ovf     = rsp_ovf_q;

endmodule
